// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter and APB master sequencer sharing one completer.
// Includes a wait-state watchdog that aborts hung transfers with an error.
module apb_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_strb,
    input  logic [NUM_REQ*3-1:0]             req_prot,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_slverr,
    output logic                             timeout_evt,
    output logic                             psel,
    output logic                             penable,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    output logic [2:0]                       pprot,
    input  logic                             pready,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pslverr
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e                 state_q;
    logic [IW-1:0]          ptr_q;
    logic [WW-1:0]          wdog_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   slverr_q;
    logic                   tevt_q;
    logic                   psel_q;
    logic                   penable_q;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic                   pwrite_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic [SW-1:0]          pstrb_q;
    logic [2:0]             pprot_q;

    // Per-requester views of the packed payload buses
    logic [ADDR_WIDTH-1:0]  addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_a [NUM_REQ];
    logic [SW-1:0]          strb_a  [NUM_REQ];
    logic [2:0]             prot_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign strb_a[g]  = req_strb[g*SW +: SW];
        assign prot_a[g]  = req_prot[g*3 +: 3];
    end

    logic [NUM_REQ-1:0]     elig;
    logic                   found_d;
    logic [IW-1:0]          win_d;
    logic [NUM_REQ-1:0]     win_oh_d;
    int                     cand;
    logic [IW-1:0]          cidx;

    // Round-robin pick: first eligible requester after the last winner
    always_comb begin
        elig     = req_valid & ~done_q;
        found_d  = 1'b0;
        win_d    = '0;
        cand     = 0;
        cidx     = '0;
        win_oh_d = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            cidx = IW'(cand);
            if (!found_d && elig[cidx]) begin
                found_d = 1'b1;
                win_d   = cidx;
            end
        end
        win_oh_d[win_d] = 1'b1;
    end

    // Transfer sequencer with registered APB and response outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RST;
            wdog_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            tevt_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
        end else begin
            done_q <= '0;
            tevt_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q   <= SETUP;
                        ptr_q     <= win_d;
                        gnt_q     <= win_oh_d;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= addr_a[win_d];
                        pwrite_q  <= req_write[win_d];
                        pwdata_q  <= wdata_a[win_d];
                        pstrb_q   <= req_write[win_d] ? strb_a[win_d] : '0;
                        pprot_q   <= prot_a[win_d];
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        gnt_q     <= '0;
                        done_q    <= gnt_q;
                        rdata_q   <= pwrite_q ? '0 : prdata;
                        slverr_q  <= pslverr;
                        wdog_q    <= '0;
                    end else if (WD_EN && (wdog_q == WD_LAST)) begin
                        // Completer hung: retire the transfer as an error
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        gnt_q     <= '0;
                        done_q    <= gnt_q;
                        rdata_q   <= '0;
                        slverr_q  <= 1'b1;
                        tevt_q    <= 1'b1;
                        wdog_q    <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign req_done    = done_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_slverr  = slverr_q;
    assign timeout_evt = tevt_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter.
// Completer model in tick(); expected responses queued per transfer.
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic              pclk;
    logic              presetn;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_write;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_strb;
    logic [N*3-1:0]    req_prot;
    logic [N-1:0]      gnt;
    logic [N-1:0]      req_done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_slverr;
    logic              timeout_evt;
    logic              psel;
    logic              penable;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic [2:0]        pprot;
    logic              pready;
    logic [DW-1:0]     prdata;
    logic              pslverr;

    apb_master_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot),
        .gnt(gnt), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .timeout_evt(timeout_evt),
        .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .pready(pready), .prdata(prdata),
        .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        slverr;
        logic        tevt;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          failures;
    int          waits;
    int          acc_cnt;
    logic [31:0] rd_key;
    logic        err_resp;

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
        if (psel && penable) begin
            pready = (acc_cnt == waits);
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
        prdata  = rd_key ^ paddr;
        pslverr = err_resp;
    endtask

    task automatic post(input int i, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p);
        req_addr[i*AW +: AW]  = a;
        req_write[i]          = w;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
        req_prot[i*3 +: 3]    = p;
        req_valid[i]          = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        presetn   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        waits     = 0;
        acc_cnt   = 0;
        rd_key    = '0;
        err_resp  = 1'b0;
        @(negedge pclk);
        tick();
        checks++; if (psel !== 1'b0) begin failures++; $display("FAIL rst_psel got=%b exp=0", psel); end
        checks++; if (penable !== 1'b0) begin failures++; $display("FAIL rst_penable got=%b exp=0", penable); end
        checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL rst_done got=%b exp=0000", req_done); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
        checks++; if ({rsp_slverr, timeout_evt} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b%b exp=00", rsp_slverr, timeout_evt); end
        checks++; if ({paddr, pwdata, pstrb, pprot, pwrite} !== '0) begin failures++; $display("FAIL rst_apb got=%h exp=0", {paddr, pwdata}); end
        presetn = 1'b1;
        tick();
        checks++; if (psel !== 1'b0) begin failures++; $display("FAIL rst_idle_psel got=%b exp=0", psel); end
        e = '{0, 0, 0, 0};
        e.idx = 0;
    endtask

    task automatic test_single_read();
        exp_t e;
        rd_key   = 32'hDEADBEEF ^ 32'h40;
        waits    = 0;
        err_resp = 1'b0;
        post(2, 32'h40, 1'b0, 32'h5555AAAA, 4'hF, 3'b010);
        sb.push_back('{2, 32'hDEADBEEF, 1'b0, 1'b0});
        tick();
        checks++; if ({psel, penable} !== 2'b10) begin failures++; $display("FAIL rd_setup got=%b%b exp=10", psel, penable); end
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rd_gnt got=%b exp=0100", gnt); end
        checks++; if (paddr !== 32'h40) begin failures++; $display("FAIL rd_paddr got=%h exp=40", paddr); end
        checks++; if ({pwrite, pstrb, pprot} !== {1'b0, 4'h0, 3'b010}) begin failures++; $display("FAIL rd_ctl got=%b %h %b exp=0 0 010", pwrite, pstrb, pprot); end
        tick();
        checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL rd_access got=%b%b exp=11", psel, penable); end
        tick();
        checks++; if (req_done !== 4'b0100) begin failures++; $display("FAIL rd_done got=%b exp=0100", req_done); end
        if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL rd_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            checks++; if (rsp_rdata !== e.rdata) begin failures++; $display("FAIL rd_rdata got=%h exp=%h", rsp_rdata, e.rdata); end
            checks++; if (rsp_slverr !== e.slverr) begin failures++; $display("FAIL rd_slverr got=%b exp=%b", rsp_slverr, e.slverr); end
        end
        checks++; if ({psel, penable, gnt} !== '0) begin failures++; $display("FAIL rd_release got=%b%b%b exp=0", psel, penable, gnt); end
        req_valid[2] = 1'b0;
        tick();
        checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0000", req_done); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold got=%h exp=deadbeef", rsp_rdata); end
    endtask

    task automatic test_write_wait();
        exp_t e;
        bit   done_seen;
        int   acc;
        int   bad;
        logic lp;
        done_seen = 0;
        acc       = 0;
        bad       = 0;
        lp        = 1'b0;
        waits     = 3;
        err_resp  = 1'b1;
        rd_key    = 32'hFFFFFFFF;
        post(0, 32'h1000, 1'b1, 32'h12345678, 4'hF, 3'b001);
        sb.push_back('{0, 32'h0, 1'b1, 1'b0});
        for (int c = 0; c < 20 && !done_seen; c++) begin
            lp = pready;
            tick();
            if (c == 0) req_wdata[31:0] = 32'hBAD0BAD0;
            if (psel && penable) begin
                acc++;
                if ({paddr, pwdata, pstrb, pwrite} !== {32'h1000, 32'h12345678, 4'hF, 1'b1}) bad++;
            end
            if (req_done != 4'b0) begin
                done_seen = 1;
                checks++; if (req_done !== 4'b0001) begin failures++; $display("FAIL wr_done got=%b exp=0001", req_done); end
                checks++; if (lp !== 1'b1) begin failures++; $display("FAIL wr_done_lat got=%b exp=1", lp); end
                e = sb.pop_front();
                checks++; if (rsp_rdata !== e.rdata) begin failures++; $display("FAIL wr_rdata got=%h exp=%h", rsp_rdata, e.rdata); end
                checks++; if (rsp_slverr !== e.slverr) begin failures++; $display("FAIL wr_slverr got=%b exp=%b", rsp_slverr, e.slverr); end
                checks++; if (timeout_evt !== e.tevt) begin failures++; $display("FAIL wr_tevt got=%b exp=%b", timeout_evt, e.tevt); end
            end
        end
        checks++; if (!done_seen) begin failures++; $display("FAIL wr_no_done got=0 exp=1"); end
        checks++; if (acc != 4) begin failures++; $display("FAIL wr_access_cycles got=%0d exp=4", acc); end
        checks++; if (bad != 0) begin failures++; $display("FAIL wr_stable got=%0d exp=0", bad); end
        req_valid[0] = 1'b0;
        err_resp     = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   order[5];
        int   ndone;
        int   ngnt;
        order = '{0, 1, 2, 3, 0};
        ndone = 0;
        ngnt  = 0;
        presetn = 1'b0;
        tick();
        presetn  = 1'b1;
        waits    = 0;
        err_resp = 1'b0;
        rd_key   = 32'h0F0F0000;
        for (int i = 0; i < N; i++)
            post(i, 32'h100 * (i + 1), 1'b0, 32'h0, 4'hF, 3'b000);
        for (int k = 0; k < 5; k++)
            sb.push_back('{order[k], rd_key ^ (32'h100 * (order[k] + 1)), 1'b0, 1'b0});
        for (int c = 0; c < 40 && ndone < 5; c++) begin
            tick();
            if (psel && !penable) begin
                ngnt++;
                checks++; if ($onehot(gnt) !== 1'b1) begin failures++; $display("FAIL rr_onehot got=%b exp=onehot", gnt); end
                if (sb.size() > 0) begin
                    checks++; if (gnt !== (4'(1) << sb[0].idx)) begin failures++; $display("FAIL rr_order got=%b exp_idx=%0d", gnt, sb[0].idx); end
                end
            end
            if (req_done != 4'b0 && sb.size() > 0) begin
                e = sb.pop_front();
                ndone++;
                checks++; if (req_done !== (4'(1) << e.idx)) begin failures++; $display("FAIL rr_done got=%b exp_idx=%0d", req_done, e.idx); end
                checks++; if (rsp_rdata !== e.rdata) begin failures++; $display("FAIL rr_rdata got=%h exp=%h", rsp_rdata, e.rdata); end
                if (ndone == 5) req_valid = '0;
            end
        end
        checks++; if (ndone != 5 || ngnt != 5) begin failures++; $display("FAIL rr_count got=%0d/%0d exp=5/5", ndone, ngnt); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   done_seen;
        int   acc;
        for (int r = 0; r < 2; r++) begin
            done_seen = 0;
            acc       = 0;
            waits     = (r == 0) ? 1000 : 15;
            rd_key    = 32'h12345678;
            post(3, 32'h300, 1'b0, 32'h0, 4'hF, 3'b000);
            if (r == 0) sb.push_back('{3, 32'h0, 1'b1, 1'b1});
            else        sb.push_back('{3, 32'h12345678 ^ 32'h300, 1'b0, 1'b0});
            for (int c = 0; c < 40 && !done_seen; c++) begin
                tick();
                if (psel && penable) acc++;
                if (req_done != 4'b0) begin
                    done_seen = 1;
                    e = sb.pop_front();
                    checks++; if (req_done !== 4'b1000) begin failures++; $display("FAIL to%0d_done got=%b exp=1000", r, req_done); end
                    checks++; if (timeout_evt !== e.tevt) begin failures++; $display("FAIL to%0d_tevt got=%b exp=%b", r, timeout_evt, e.tevt); end
                    checks++; if (rsp_slverr !== e.slverr) begin failures++; $display("FAIL to%0d_slverr got=%b exp=%b", r, rsp_slverr, e.slverr); end
                    checks++; if (rsp_rdata !== e.rdata) begin failures++; $display("FAIL to%0d_rdata got=%h exp=%h", r, rsp_rdata, e.rdata); end
                end
            end
            checks++; if (!done_seen) begin failures++; $display("FAIL to%0d_no_done got=0 exp=1", r); end
            checks++; if (acc != 16) begin failures++; $display("FAIL to%0d_access_cycles got=%0d exp=16", r, acc); end
            req_valid[3] = 1'b0;
            tick();
            checks++; if ({timeout_evt, psel} !== 2'b00) begin failures++; $display("FAIL to%0d_after got=%b%b exp=00", r, timeout_evt, psel); end
        end
    endtask

    task automatic test_hold_past_done();
        exp_t e;
        bit   done_seen;
        waits    = 0;
        rd_key   = 32'h0;
        for (int r = 0; r < 2; r++) begin
            done_seen = 0;
            post(1, 32'h200 + 4 * r, 1'b1, 32'hCAFEF00D, 4'h3, 3'b000);
            sb.push_back('{1, 32'h0, 1'b0, 1'b0});
            tick();
            checks++; if ({psel, gnt, paddr} !== {1'b1, 4'b0010, 32'h200 + 32'(4 * r)}) begin failures++; $display("FAIL hold%0d_grant got=%b %b %h", r, psel, gnt, paddr); end
            checks++; if (pstrb !== 4'h3) begin failures++; $display("FAIL hold%0d_pstrb got=%h exp=3", r, pstrb); end
            for (int c = 0; c < 10 && !done_seen; c++) begin
                tick();
                if (req_done != 4'b0) begin
                    done_seen = 1;
                    e = sb.pop_front();
                    checks++; if (req_done !== (4'(1) << e.idx)) begin failures++; $display("FAIL hold%0d_done got=%b exp_idx=%0d", r, req_done, e.idx); end
                end
            end
            checks++; if (!done_seen) begin failures++; $display("FAIL hold%0d_no_done got=0 exp=1", r); end
            if (r == 0) begin
                tick();
                checks++; if ({psel, gnt} !== 5'b0) begin failures++; $display("FAIL hold_regrant got=%b %b exp=0", psel, gnt); end
            end
            req_valid[1] = 1'b0;
            tick();
            checks++; if (psel !== 1'b0) begin failures++; $display("FAIL hold%0d_idle got=%b exp=0", r, psel); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   done_seen;
        done_seen = 0;
        waits     = 1000;
        post(2, 32'h500, 1'b0, 32'h0, 4'hF, 3'b000);
        tick();
        tick();
        tick();
        checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL rm_in_access got=%b%b exp=11", psel, penable); end
        #2;
        presetn = 1'b0;
        #1;
        checks++; if ({psel, penable, gnt, req_done} !== '0) begin failures++; $display("FAIL rm_async got=%b%b %b %b exp=0", psel, penable, gnt, req_done); end
        rd_key = 32'hA5A5A5A5;
        for (int i = 0; i < N; i++)
            post(i, 32'h600 + 32'(16 * i), 1'b0, 32'h0, 4'hF, 3'b000);
        @(negedge pclk);
        checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL rm_no_done got=%b exp=0000", req_done); end
        presetn = 1'b1;
        waits   = 0;
        sb.push_back('{0, 32'hA5A5A5A5 ^ 32'h600, 1'b0, 1'b0});
        tick();
        checks++; if ({psel, gnt} !== {1'b1, 4'b0001}) begin failures++; $display("FAIL rm_first got=%b %b exp=1 0001", psel, gnt); end
        for (int c = 0; c < 10 && !done_seen; c++) begin
            tick();
            if (req_done != 4'b0) begin
                done_seen = 1;
                req_valid = '0;
                e = sb.pop_front();
                checks++; if (req_done !== (4'(1) << e.idx)) begin failures++; $display("FAIL rm_done got=%b exp_idx=%0d", req_done, e.idx); end
                checks++; if (rsp_rdata !== e.rdata) begin failures++; $display("FAIL rm_rdata got=%h exp=%h", rsp_rdata, e.rdata); end
            end
        end
        checks++; if (!done_seen) begin failures++; $display("FAIL rm_no_done2 got=0 exp=1"); end
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_read();
        test_write_wait();
        test_round_robin();
        test_timeout();
        test_hold_past_done();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin arbiter plus APB master sequencer; shares one APB completer path (bridge/slave fabric) between NUM_REQ local requesters.
- Each requester posts one transfer at a time; the block grants one, drives the APB SETUP/ACCESS phases, waits on pready, and returns rdata/slverr to the winner.
- Includes a wait-state watchdog that aborts hung transfers with an error.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width (multiple of 8).
- TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables the watchdog.

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request; held until its req_done.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*(DATA_WIDTH/8)  packed byte strobes.
- req_prot  in  NUM_REQ*3  packed pprot values.
- gnt  out  NUM_REQ  one-hot grant; high from SETUP through the last ACCESS cycle.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_WIDTH  read data; valid while req_done is high.
- rsp_slverr  out  1  error flag; valid while req_done is high.
- timeout_evt  out  1  one-cycle pulse on watchdog abort.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes; all-zero on reads.
- pprot  out  3  APB protection.
- pready  in  1  completer ready.
- prdata  in  DATA_WIDTH  completer read data.
- pslverr  in  1  completer error.

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0; wdog=0; RR pointer=NUM_REQ-1, so req 0 has first priority.
- FSM IDLE -> SETUP -> ACCESS -> IDLE, all outputs registered.
- IDLE: if any eligible req_valid, pick the first set bit searching from pointer+1 with wrap. Next edge: register that requester's addr/write/wdata/strb/prot onto the APB outputs, set gnt, psel=1, penable=0, pointer=winner, go to SETUP.
- Eligibility: the requester whose req_done is high this cycle is masked from arbitration, so a still-held req_valid is not re-granted.
- SETUP: one cycle, then penable=1 and go to ACCESS. APB outputs stay stable through ACCESS.
- ACCESS, pready=0: stay; wdog++.
- ACCESS, pready=1: next edge psel=penable=0, gnt=0, req_done[winner]=1, rsp_rdata=prdata on reads (0 on writes), rsp_slverr=pslverr, wdog=0, go to IDLE.
- Watchdog: if TIMEOUT!=0 and pready=0 with wdog==TIMEOUT-1, abort exactly as completion but rsp_slverr=1, rsp_rdata=0, timeout_evt=1. A pready arriving in the same cycle wins over the abort.
- Minimum transfer: request seen at cycle T, SETUP at T+1, ACCESS at T+2, done at T+3 (zero wait states). Throughput is one transfer per 3 cycles; ACCESS->SETUP chaining is not used.
- rsp_rdata/rsp_slverr hold their value after the done pulse until the next completion.
- Payload changes by a requester after grant are ignored, since the payload is captured at grant.
- req_valid dropped by the granted requester mid-transfer: the transfer still completes and done still pulses.
- Reset mid-transfer: immediate return to reset values; no done pulse; psel drops asynchronously.

Test Plan:
- Single read, req 2, addr 0x40, pready high in first ACCESS -> psel at T+1, penable at T+2, req_done[2] and rsp_rdata=prdata=0xDEADBEEF at T+3, rsp_slverr=0.
- Write with 3 wait states, req 0, wdata 0x12345678, strb 0xF -> paddr/pwdata stable for 4 ACCESS cycles, pstrb=0xF, done one cycle after pready.
- All 4 requesters valid continuously after reset -> grant order 0,1,2,3,0; every gnt one-hot; no requester granted twice while others wait.
- TIMEOUT=16, pready held low -> after 16 ACCESS cycles: timeout_evt=1, rsp_slverr=1, rsp_rdata=0, state IDLE. Repeat with pready rising on the 16th cycle -> normal completion, no timeout_evt.
- Req 1 alone holds req_valid one cycle past done -> no second grant; after a deassert/reassert, a new transfer starts.
- presetn low during ACCESS -> psel, penable, gnt, req_done = 0 immediately; after release, req 0 wins first.
